sensor_poll_scheduler: RTL and testbench

SENSOR_POLL_SCHEDULER -- requirements
Module: sensor_poll_scheduler

---
 rtl/sensor_sched_pkg.sv | 21 ++
 rtl/sched_period_timer.sv | 36 +++
 rtl/sensor_poll_scheduler.sv | 150 +++++++++++++++
 tb/tb_sensor_poll_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_sched_pkg.sv
// Shared types and constants for the sensor poll scheduler.
package sensor_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RECOVER = 2'd3
  } sched_state_e;

  localparam logic [7:0] CMD_TEMP    = 8'h54;
  localparam logic [7:0] CMD_DIST    = 8'h44;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [1:0] CR_CNT_TEMP = 2'd2;
  localparam logic [1:0] CR_CNT_DIST = 2'd1;

  function automatic logic is_valid_cmd(input logic [7:0] c);
    return (c == CMD_TEMP) || (c == CMD_DIST);
  endfunction

endpackage

// File: rtl/sched_period_timer.sv
// Free-running 0..PERIOD_CYCLES-1 counter; each wrap raises a sticky request
// that the consumer clears. A wrap in the same cycle as a clear keeps it set.
module sched_period_timer #(
  parameter int PERIOD_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic req_o
);
  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(PERIOD_CYCLES - 1));

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    req_d = wrap | (req_q & ~clr_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      req_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      req_q <= req_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Issues 'T'/'D' commands (host or auto-poll) to the crossbar, waits for CR
// replies, and resets the crossbar on timeout. Auto-poll needs SENSOR_SCHED_AUTO_POLL_EN.
//   state   | meaning
//   IDLE    | pick pending host command, else auto request
//   ISSUE   | drive cmd_out for one cycle
//   WAIT    | count CR replies, watch timeout
//   RECOVER | hold xbar_rst_n low for two cycles
module sensor_poll_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 100_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] host_cmd,
  input  logic       host_cmd_valid,
  output logic       host_ready,
  output logic [7:0] cmd_out,
  input  logic [7:0] tx_byte,
  input  logic       tx_byte_valid,
  output logic       xbar_rst_n,
  output logic       busy,
  output logic       active_dist,
  output logic       done,
  output logic       timeout,
  output logic [7:0] err_count
);
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  if (PERIOD_CYCLES < 4 || TIMEOUT_CYCLES < 4) begin : g_cfg_check
    $error("sensor_poll_scheduler: PERIOD_CYCLES and TIMEOUT_CYCLES must be >= 4");
  end

  sched_state_e  state_q, state_d;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_cmd_q, pend_cmd_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          auto_dist_q, auto_dist_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]    cr_cnt_q, cr_cnt_d;
  logic          rec_cnt_q, rec_cnt_d;
  logic [7:0]    err_q, err_d;

  logic       auto_req;
  logic       accept, take_host, take_auto;
  logic       cr_hit, complete, expire;
  logic [1:0] cr_need, cr_sum;

  assign host_ready = !pend_valid_q || (state_q == ST_IDLE);
  assign accept     = host_cmd_valid && host_ready;
  assign take_host  = (state_q == ST_IDLE) && pend_valid_q;
  assign take_auto  = (state_q == ST_IDLE) && !pend_valid_q && auto_req;

  assign cr_hit   = tx_byte_valid && (tx_byte == ASCII_CR);
  assign cr_need  = (cmd_q == CMD_TEMP) ? CR_CNT_TEMP : CR_CNT_DIST;
  assign cr_sum   = cr_cnt_q + {1'b0, cr_hit};
  assign complete = (state_q == ST_WAIT) && (cr_sum >= cr_need);
  // Completion wins over a timeout landing in the same cycle.
  assign expire   = (state_q == ST_WAIT) && !complete &&
                    (wait_cnt_q == WW'(TIMEOUT_CYCLES - 1));

`ifdef SENSOR_SCHED_AUTO_POLL_EN
  logic auto_clr;
  assign auto_clr = take_auto;

  sched_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_period_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (auto_clr),
    .req_o (auto_req)
  );
`else
  assign auto_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= 8'h00;
      cmd_q        <= 8'h00;
      auto_dist_q  <= 1'b0;
      wait_cnt_q   <= '0;
      cr_cnt_q     <= 2'd0;
      rec_cnt_q    <= 1'b0;
      err_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
      cmd_q        <= cmd_d;
      auto_dist_q  <= auto_dist_d;
      wait_cnt_q   <= wait_cnt_d;
      cr_cnt_q     <= cr_cnt_d;
      rec_cnt_q    <= rec_cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (take_host || take_auto) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (complete)    state_d = ST_IDLE;
        else if (expire) state_d = ST_RECOVER;
      end
      ST_RECOVER: if (rec_cnt_q) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    cmd_d        = cmd_q;
    auto_dist_d  = auto_dist_q;
    if (take_host) begin
      pend_valid_d = 1'b0;
      cmd_d        = pend_cmd_q;
    end else if (take_auto) begin
      cmd_d       = auto_dist_q ? CMD_DIST : CMD_TEMP;
      auto_dist_d = ~auto_dist_q;
    end
    // Slot may refill in the same cycle it drains; bad bytes are just dropped.
    if (accept && is_valid_cmd(host_cmd)) begin
      pend_valid_d = 1'b1;
      pend_cmd_d   = host_cmd;
    end
    wait_cnt_d = (state_q == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
    cr_cnt_d   = (state_q == ST_WAIT) ? cr_sum : 2'd0;
    rec_cnt_d  = (state_q == ST_RECOVER) ? ~rec_cnt_q : 1'b0;
    err_d      = (expire && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_comb begin
    cmd_out     = (state_q == ST_ISSUE) ? cmd_q : 8'h00;
    busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    active_dist = busy && (cmd_q == CMD_DIST);
    done        = complete;
    timeout     = expire;
    xbar_rst_n  = (state_q != ST_RECOVER);
    err_count   = err_q;
  end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Self-checking bench for sensor_poll_scheduler: directed table, hand sequences
// and a randomized run against a behavioural model.
module tb_sensor_poll_scheduler;
  localparam int P  = 20;
  localparam int TO = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] host_cmd;
  logic       host_cmd_valid;
  logic       host_ready;
  logic [7:0] cmd_out;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       xbar_rst_n, busy, active_dist, done, timeout;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  sensor_poll_scheduler #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .host_cmd(host_cmd), .host_cmd_valid(host_cmd_valid),
    .host_ready(host_ready), .cmd_out(cmd_out), .tx_byte(tx_byte),
    .tx_byte_valid(tx_byte_valid), .xbar_rst_n(xbar_rst_n), .busy(busy),
    .active_dist(active_dist), .done(done), .timeout(timeout), .err_count(err_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // {cmd_out, busy, done, host_ready, active_dist, timeout, xbar_rst_n, err_count}
  function automatic logic [21:0] dut_vec();
    return {cmd_out, busy, done, host_ready, active_dist, timeout, xbar_rst_n, err_count};
  endfunction

  localparam logic [21:0] RESET_VEC = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};

  task automatic drive(input bit hv, input logic [7:0] hc, input bit tv, input logic [7:0] tb);
    host_cmd_valid = hv;
    host_cmd       = hc;
    tx_byte_valid  = tv;
    tx_byte        = tb;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    rst = 1'b0;
    #1;
    check("reset_vals", 32'(dut_vec()), 32'(RESET_VEC));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Behavioural reference: tracks what is outstanding, not how the RTL encodes it.
  bit         m_pend;
  logic [7:0] m_pend_cmd;
  bit         m_auto_req;
  int         m_tick;
  bit         m_auto_next_d;
  bit         m_issue;
  bit         m_waiting;
  int         m_wait_cycles;
  int         m_crs_left;
  int         m_recover_left;
  logic [7:0] m_cur;
  int         m_errs;

  task automatic model_reset();
    m_pend = 0; m_pend_cmd = 8'h00; m_auto_req = 0; m_tick = 0; m_auto_next_d = 0;
    m_issue = 0; m_waiting = 0; m_wait_cycles = 0; m_crs_left = 0;
    m_recover_left = 0; m_cur = 8'h00; m_errs = 0;
  endtask

  function automatic bit m_idle();
    return !m_issue && !m_waiting && (m_recover_left == 0);
  endfunction

  function automatic bit m_cr_now();
    return tx_byte_valid && (tx_byte == 8'h0D);
  endfunction

  function automatic bit m_done_now();
    return m_waiting && ((m_crs_left - (m_cr_now() ? 1 : 0)) <= 0);
  endfunction

  function automatic bit m_to_now();
    return m_waiting && !m_done_now() && (m_wait_cycles == TO - 1);
  endfunction

  function automatic logic [21:0] m_expect();
    logic [7:0] c;
    bit         b;
    c = m_issue ? m_cur : 8'h00;
    b = m_issue || m_waiting;
    return {c, b, m_done_now(), (!m_pend || m_idle()), (b && m_cur == 8'h44),
            m_to_now(), (m_recover_left == 0), 8'((m_errs > 255) ? 255 : m_errs)};
  endfunction

  task automatic model_step();
    bit idle, d, t, acc, cr;
    idle = m_idle();
    d    = m_done_now();
    t    = m_to_now();
    acc  = host_cmd_valid && (!m_pend || idle);
    cr   = m_cr_now();
    if (idle) begin
      if (m_pend) begin
        m_issue = 1; m_cur = m_pend_cmd; m_pend = 0;
      end else if (m_auto_req) begin
        m_issue = 1; m_cur = m_auto_next_d ? 8'h44 : 8'h54;
        m_auto_next_d = !m_auto_next_d; m_auto_req = 0;
      end
    end else if (m_issue) begin
      m_issue = 0; m_waiting = 1; m_wait_cycles = 0;
      m_crs_left = (m_cur == 8'h54) ? 2 : 1;
    end else if (m_waiting) begin
      if (cr) m_crs_left--;
      if (d) m_waiting = 0;
      else if (t) begin m_waiting = 0; m_recover_left = 2; m_errs++; end
      else m_wait_cycles++;
    end else begin
      m_recover_left--;
    end
    if (acc && (host_cmd == 8'h54 || host_cmd == 8'h44)) begin
      m_pend = 1; m_pend_cmd = host_cmd;
    end
`ifdef SENSOR_SCHED_AUTO_POLL_EN
    if (m_tick == P - 1) begin m_tick = 0; m_auto_req = 1; end
    else m_tick++;
`endif
  endtask

  typedef struct {
    bit         hv;
    logic [7:0] hc;
    bit         tv;
    logic [7:0] tb;
    logic [7:0] e_cmd;
    bit         e_busy, e_done, e_ready, e_dist;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int issue_at, to_at, to_cnt, xlow, xfirst, done_seen, nz, n;
    int at[3];
    logic [7:0] val[3];
    bit quiet;
    logic [7:0] hc;

    //          hv  hc     tv  tb     cmd    busy done rdy dist
    tbl[0]  = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 0};
    tbl[1]  = '{1, 8'h41, 0, 8'h00, 8'h00, 0, 0, 1, 0};
    tbl[2]  = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 0};
    tbl[3]  = '{1, 8'h54, 0, 8'h00, 8'h00, 0, 0, 1, 0};
    tbl[4]  = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 0};
    tbl[5]  = '{0, 8'h00, 0, 8'h00, 8'h54, 1, 0, 1, 0};
    tbl[6]  = '{1, 8'h54, 1, 8'h41, 8'h00, 1, 0, 1, 0};
    tbl[7]  = '{0, 8'h00, 1, 8'h0D, 8'h00, 1, 0, 0, 0};
    tbl[8]  = '{1, 8'h44, 0, 8'h0D, 8'h00, 1, 0, 0, 0};
    tbl[9]  = '{0, 8'h00, 1, 8'h0D, 8'h00, 1, 1, 0, 0};
    tbl[10] = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 0};
    tbl[11] = '{0, 8'h00, 0, 8'h00, 8'h54, 1, 0, 1, 0};
    tbl[12] = '{0, 8'h00, 1, 8'h0D, 8'h00, 1, 0, 1, 0};
    tbl[13] = '{0, 8'h00, 1, 8'h0D, 8'h00, 1, 1, 1, 0};
    tbl[14] = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 0};
    tbl[15] = '{1, 8'h44, 1, 8'h0D, 8'h00, 0, 0, 1, 0};
    tbl[16] = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 0};
    tbl[17] = '{0, 8'h00, 0, 8'h00, 8'h44, 1, 0, 1, 1};
    tbl[18] = '{0, 8'h00, 1, 8'h0D, 8'h00, 1, 1, 1, 1};
    tbl[19] = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 0};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].hv, tbl[i].hc, tbl[i].tv, tbl[i].tb);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(dut_vec()),
            32'({tbl[i].e_cmd, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_ready,
                 tbl[i].e_dist, 1'b0, 1'b1, 8'h00}));
      @(posedge clk);
      #1;
    end

    // 'D' with no reply: timeout, recovery pulse, error count
    do_reset();
    issue_at = -1; to_at = -1; to_cnt = 0; xlow = 0; xfirst = -1; done_seen = 0;
    drive(1'b1, 8'h44, 1'b0, 8'h00);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cmd_out == 8'h44 && issue_at < 0) issue_at = c;
      if (timeout) begin to_cnt++; if (to_at < 0) to_at = c; end
      if (!xbar_rst_n) begin xlow++; if (xfirst < 0) xfirst = c; end
      if (done) done_seen = 1;
      if (c == 35) begin
        check("to_err_count", 32'(err_count), 32'd1);
        check("to_idle_busy", 32'(busy), 32'd0);
      end
      @(posedge clk);
      #1;
      drive(1'b0, 8'h00, 1'b0, 8'h00);
    end
    check("accept_to_issue", 32'(issue_at), 32'd2);
    check("to_latency", 32'(to_at - issue_at), 32'd30);
    check("to_pulse_width", 32'(to_cnt), 32'd1);
    check("xbar_low_len", 32'(xlow), 32'd2);
    check("xbar_low_start", 32'(xfirst), 32'(to_at + 1));
    check("to_no_done", 32'(done_seen), 32'd0);

    // Reset while a command is in WAIT
    drive(1'b1, 8'h54, 1'b0, 8'h00);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      drive(1'b0, 8'h00, 1'b0, 8'h00);
    end
    @(negedge clk);
    check("rw_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rw_reset_vals", 32'(dut_vec()), 32'(RESET_VEC));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rw_hold_quiet", 32'({busy, done, timeout, cmd_out}), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    nz = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cmd_out != 8'h00 || done || timeout) nz++;
      @(posedge clk);
      #1;
    end
    check("rw_abandoned", 32'(nz), 32'd0);

    // Randomized traffic against the model
    do_reset();
    model_reset();
    quiet = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0) quiet = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       hc = 8'h54;
        1:       hc = 8'h44;
        2:       hc = 8'h41;
        default: hc = 8'($urandom);
      endcase
      drive(($urandom_range(0, 7) == 0), hc,
            quiet ? 1'b0 : ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0) ? 8'h0D : 8'($urandom));
      @(negedge clk);
      check($sformatf("rand_cyc%0d", cyc), 32'(dut_vec()), 32'(m_expect()));
      @(posedge clk);
      model_step();
      #1;
    end

`ifdef SENSOR_SCHED_AUTO_POLL_EN
    // Auto sequence with prompt replies: T, D, T every PERIOD cycles
    do_reset();
    drive(1'b0, 8'h00, 1'b1, 8'h0D);
    n = 0;
    for (int k = 0; k < 3; k++) begin at[k] = -1; val[k] = 8'h00; end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (cmd_out != 8'h00 && n < 3) begin at[n] = c; val[n] = cmd_out; n++; end
      @(posedge clk);
      #1;
    end
    check("auto_count", 32'(n), 32'd3);
    check("auto_cmd0", 32'(val[0]), 32'h54);
    check("auto_cmd1", 32'(val[1]), 32'h44);
    check("auto_cmd2", 32'(val[2]), 32'h54);
    check("auto_first_at", 32'(at[0]), 32'd21);
    check("auto_gap01", 32'(at[1] - at[0]), 32'd20);
    check("auto_gap12", 32'(at[2] - at[1]), 32'd20);

    // Host 'D' and auto request meet in the same IDLE cycle
    do_reset();
    n = 0;
    for (int k = 0; k < 3; k++) begin at[k] = -1; val[k] = 8'h00; end
    for (int c = 0; c < 40; c++) begin
      drive((c == 19), (c == 19) ? 8'h44 : 8'h00, 1'b1, 8'h0D);
      @(negedge clk);
      if (cmd_out != 8'h00 && n < 2) begin at[n] = c; val[n] = cmd_out; n++; end
      @(posedge clk);
      #1;
    end
    check("tie_first_cmd", 32'(val[0]), 32'h44);
    check("tie_first_at", 32'(at[0]), 32'd21);
    check("tie_second_cmd", 32'(val[1]), 32'h54);
    check("tie_second_at", 32'(at[1]), 32'd24);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
